dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Single-ported, word-organised data-memory responder for the RV32I pipeline's data port.
- It answers the core's read/write requests with a fixed, parameterised latency.
- Writes honour the 4-bit byte-enable mask that the pipeline control word produces.
- It is the slave end of the data-memory handshake; the MEM stage is the initiator. It is used as the memory model in integration benches and as the on-chip scratch RAM.

Parameters:
- ADDR_WIDTH, 8, log2 of depth in 32-bit words (depth = 256 words = 1 KiB).
- LATENCY, 3, cycles from request acceptance to mem_resp; legal range 1..15.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- mem_read  input  1  read request, held by initiator until mem_resp
- mem_write  input  1  write request, held by initiator until mem_resp
- mem_address  input  32  byte address; bits [1:0] ignored (lanes selected by mask)
- mem_wdata  input  32  write data, lane-aligned
- mem_byte_enable  input  4  write lane mask; bit i enables byte i (bits [8i+7:8i])
- mem_rdata  output  32  read data, valid when mem_resp=1
- mem_resp  output  1  one-cycle completion pulse
- mem_error  output  1  qualifies mem_resp: request was illegal, no side effects

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, latency counter=0.
  - mem_resp=0, mem_error=0, mem_rdata=0.
  - Array contents are NOT cleared by reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read|mem_write is high at a rising edge, latch address, wdata, mask, read flag, write flag.
  - Load counter with LATENCY-1.
  - Go to WAIT, or to RESP directly if LATENCY=1.
- WAIT:
  - Decrement counter each cycle. On the edge where counter==1, enter RESP.
  - Inputs are ignored in WAIT; only latched values are used.
- RESP:
  - mem_resp=1 for exactly one cycle, then IDLE unconditionally.
  - Requests are not sampled in RESP. The initiator deasserts, or presents its next request, in the cycle after mem_resp.
  - Minimum request-to-request spacing is LATENCY+1 cycles.
- Latency: request first high in cycle T (accepted at end of T) -> mem_resp high in cycle T+LATENCY.
- Commit point: the array write and read capture occur on the edge entering RESP. mem_rdata is registered at that edge.
- Read: mem_rdata = full word at index mem_address[ADDR_WIDTH+1:2]; mask ignored.
- Write: for each i with mask[i]=1, byte i <= wdata byte i; other bytes are unchanged.
  - A mask of 0000 is a legal no-op that still responds.
  - mem_rdata keeps its previous value on writes.
- mem_rdata holds its value outside RESP until the next read commit.
- Error cases (mem_error=1 with mem_resp, mem_rdata=0, no array write):
  - mem_read and mem_write both high at acceptance.
  - Address out of range: mem_address[31:ADDR_WIDTH+2] nonzero.
  - Latency is unchanged in error cases.
- Read-after-write: a read accepted after a write's mem_resp returns the written data. There is no bypass path; none is needed.
- Reset mid-operation:
  - rst in WAIT aborts the request, with no array write and no mem_resp.
  - rst coincident with the commit edge wins, so no write occurs.
  - After rst deasserts, the block is in IDLE and accepts a request in the next cycle.
- mem_error is only ever high together with mem_resp.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x00000010 with mask 1111, then read 0x00000010 -> each mem_resp arrives exactly 3 cycles after request; read returns 0xDEADBEEF; mem_error=0.
- Write 0x11223344 to 0x20 with mask 1111, then write 0xAABBCCDD to 0x22 with mask 0101, then read 0x20 -> 0x11BB33DD.
- Write with mask 0000 to 0x20, then read 0x20 -> value unchanged from previous contents; write still gets its mem_resp.
- Read 0x00000400 with ADDR_WIDTH=8 -> mem_resp with mem_error=1, mem_rdata=0; read of word 0 is unaffected.
- mem_read and mem_write both high, address 0x4, wdata 0xFFFFFFFF -> mem_error=1; subsequent read of 0x4 returns the prior contents.
- rst pulsed one cycle into WAIT of a write 0x55555555 to 0x8 -> no mem_resp; a later read of 0x8 returns the old value. Repeat with LATENCY=1 and check back-to-back requests complete every 2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-organised data-memory responder for the RV32I data port.
// Answers each held read/write request with a single mem_resp pulse a fixed LATENCY cycles after acceptance.
module dmem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_error
);

  localparam int         DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic                  w_accept;
  logic                  w_commit;

  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic [3:0]            r_be;
  logic                  r_rd;
  logic                  r_wr;
  logic                  r_err;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_req_err;
  logic [ADDR_WIDTH-1:0] w_c_idx;
  logic [31:0]           w_c_wdata;
  logic [3:0]            w_c_be;
  logic                  w_c_rd;
  logic                  w_c_wr;
  logic                  w_c_err;
  logic                  w_unused;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Byte offset is meaningless for a word array; lanes come from the mask.
  assign w_unused  = ^mem_address[1:0];
  assign w_req_err = (mem_read & mem_write) | (|mem_address[31:ADDR_WIDTH+2]);

  // With LATENCY=1 the commit edge is the acceptance edge, so the live
  // inputs stand in for the not-yet-latched request fields.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_c_idx   = mem_address[ADDR_WIDTH+1:2];
      w_c_wdata = mem_wdata;
      w_c_be    = mem_byte_enable;
      w_c_rd    = mem_read;
      w_c_wr    = mem_write;
      w_c_err   = w_req_err;
    end else begin
      w_c_idx   = r_idx;
      w_c_wdata = r_wdata;
      w_c_be    = r_be;
      w_c_rd    = r_rd;
      w_c_wr    = r_wr;
      w_c_err   = r_err;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_read | mem_write) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = LAT_M1;
          w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Reset on the commit edge must suppress the write, so it gates the commit.
  assign w_commit = (w_state_nxt == S_RESP) && (r_state != S_RESP) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_rd  <= mem_read;
        r_wr  <= mem_write;
        r_err <= w_req_err;
      end
      if (w_commit) begin
        if (w_c_err)     r_rdata <= 32'd0;
        else if (w_c_rd) r_rdata <= r_mem[w_c_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx   <= mem_address[ADDR_WIDTH+1:2];
      r_wdata <= mem_wdata;
      r_be    <= mem_byte_enable;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_c_wr && !w_c_err) begin
      r_mem[w_c_idx] <= merge_bytes(r_mem[w_c_idx], w_c_wdata, w_c_be);
    end
  end

  assign mem_resp  = (r_state == S_RESP);
  assign mem_error = (r_state == S_RESP) & r_err;
  assign mem_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder: one instance at LATENCY=3 and one at LATENCY=1,
// both compared against a word-array reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        rd  [2];
  logic        wr  [2];
  logic [31:0] adr [2];
  logic [31:0] wdt [2];
  logic [3:0]  be  [2];
  logic [31:0] rdata [2];
  logic        resp  [2];
  logic        err   [2];

  int          lat [2] = '{3, 1};
  logic [31:0] mdl [2][256];
  logic [31:0] last_rd [2];
  int          resp_cyc [2];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.ADDR_WIDTH(8), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst[0]), .mem_read(rd[0]), .mem_write(wr[0]),
    .mem_address(adr[0]), .mem_wdata(wdt[0]), .mem_byte_enable(be[0]),
    .mem_rdata(rdata[0]), .mem_resp(resp[0]), .mem_error(err[0]));

  dmem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .mem_read(rd[1]), .mem_write(wr[1]),
    .mem_address(adr[1]), .mem_wdata(wdt[1]), .mem_byte_enable(be[1]),
    .mem_rdata(rdata[1]), .mem_resp(resp[1]), .mem_error(err[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete request/response; returns the observed read data.
  task automatic txn(input int d, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] m, output logic [31:0] obs);
    int          k;
    bit          got;
    bit          bad;
    int          idx;
    logic [31:0] exp_rd;
    @(negedge clk);
    rd[d] = r; wr[d] = w; adr[d] = a; wdt[d] = wd; be[d] = m;
    k = 0; got = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (resp[d]) got = 1;
      else chk("err_without_resp", {31'd0, err[d]}, 32'd0);
    end
    obs = rdata[d];
    rd[d] = 1'b0; wr[d] = 1'b0;
    if (!got) chk("timeout", 32'd0, 32'd1);
    chk("latency", k, lat[d]);
    bad = (r && w) || (a >= 32'd1024);
    idx = (a >> 2) % 256;
    if (bad) exp_rd = 32'd0;
    else if (r) exp_rd = mdl[d][idx];
    else begin
      for (int i = 0; i < 4; i++)
        if (m[i]) mdl[d][idx][8*i +: 8] = wd[8*i +: 8];
      exp_rd = last_rd[d];
    end
    last_rd[d] = exp_rd;
    chk("error_flag", {31'd0, err[d]}, {31'd0, bad});
    chk("rdata", obs, exp_rd);
    resp_cyc[d] = cyc;
  endtask

  // Write aborted by a reset pulse issued 'at_k' cycles after the request appears.
  task automatic rst_abort(input int d, input logic [31:0] a, input logic [31:0] wd, input int at_k);
    @(negedge clk);
    rd[d] = 1'b0; wr[d] = 1'b1; adr[d] = a; wdt[d] = wd; be[d] = 4'hF;
    repeat (at_k) @(negedge clk);
    rst[d] = 1'b1;
    @(negedge clk);
    rst[d] = 1'b0; wr[d] = 1'b0;
    last_rd[d] = 32'd0;
    chk("rst_rdata", rdata[d], 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rst_no_resp", {31'd0, resp[d]}, 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] o;
    logic [31:0] a;
    logic [31:0] wd;
    int          prev;
    int          kind;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
      adr[d] = '0; wdt[d] = '0; be[d] = '0; last_rd[d] = '0; resp_cyc[d] = 0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("reset_resp", {31'd0, resp[d]}, 32'd0);
      chk("reset_error", {31'd0, err[d]}, 32'd0);
      chk("reset_rdata", rdata[d], 32'd0);
    end

    // Give every word a defined value.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++)
        txn(d, 1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, o);

    txn(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, o);
    txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, o);
    chk("tp_read_10", o, 32'hDEADBEEF);

    txn(0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, o);
    txn(0, 1'b0, 1'b1, 32'h22, 32'hAABBCCDD, 4'b0101, o);
    txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, o);
    chk("tp_mask_0101", o, 32'h11BB33DD);
    txn(0, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, o);
    txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, o);
    chk("tp_mask_0000", o, 32'h11BB33DD);

    txn(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0, o);
    chk("tp_oor_rdata", o, 32'h0);
    txn(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, o);

    txn(0, 1'b1, 1'b1, 32'h4, 32'hFFFFFFFF, 4'hF, o);
    txn(0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, o);

    rst_abort(0, 32'h8, 32'h55555555, 1);
    txn(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, o);
    rst_abort(0, 32'h8, 32'h55555555, 2);
    txn(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, o);

    rst_abort(1, 32'h8, 32'h55555555, 0);
    txn(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, o);
    for (int i = 0; i < 8; i++) begin
      prev = resp_cyc[1];
      txn(1, i[0], !i[0], 32'h8, $urandom, 4'(i), o);
      chk("b2b_spacing", resp_cyc[1] - prev, 2);
    end

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        kind = $urandom_range(0, 19);
        a    = {22'd0, 8'($urandom), 2'($urandom)};
        wd   = $urandom;
        if (kind == 0) a = a | ({$urandom} << 10) | 32'h400;
        if (kind == 1) txn(d, 1'b1, 1'b1, a, wd, 4'($urandom), o);
        else if (kind < 11) txn(d, 1'b1, 1'b0, a, wd, 4'($urandom), o);
        else txn(d, 1'b0, 1'b1, a, wd, 4'($urandom), o);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
